wave_player: RTL and testbench

- Sample-playback source for the analog front end: the output-side counterpart of the ADC capture/averaging path.
- Holds a 1024 x 12-bit waveform memory that is loaded through a simple write port.
- On `start`, plays the memory out to the DAC at a fixed sample period of SMP_DIV clocks, either once or looping.
- Flags each new sample with a one-cycle strobe.

---
 rtl/wave_player.sv | 126 ++++++++++++
 tb/tb_wave_player.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wave_player.sv
// Waveform playback source: 1024 x 12-bit sample memory streamed to the DAC
// at one sample every SMP_DIV clocks, single-shot or looping.
module wave_player #(
    parameter int DW      = 12,
    parameter int AW      = 10,
    parameter int SMP_DIV = 98
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [AW:0]   len,
    output logic [DW-1:0] dac_data,
    output logic          dac_strobe,
    output logic          busy,
    output logic          done
);

    localparam int DCW = $clog2(SMP_DIV);
    localparam logic [DCW-1:0] DIV_MAX = DCW'(SMP_DIV - 1);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0]  mem [0:(1<<AW)-1];
    logic [DW-1:0]  rd_data;
    logic [AW-1:0]  rd_addr;
    logic [AW:0]    len_q;
    logic [DCW-1:0] div_cnt;

    logic accept;
    logic tick;
    logic last;
    logic strobe_d;
    logic busy_d;
    logic done_d;

    // rd_addr only moves on a tick, so the registered read has at least one
    // spare cycle to settle before the next tick consumes it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    always_comb begin
        accept = (state_q == IDLE) && start && !stop;
        tick   = (state_q == PLAY) && !stop && (div_cnt == DIV_MAX);
        last   = ({1'b0, rd_addr} == (len_q - (AW+1)'(1)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (tick && last && !loop_en) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        strobe_d = tick;
        busy_d   = (state_d == PLAY);
        done_d   = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dac_data   <= '0;
            dac_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_addr    <= '0;
            div_cnt    <= '0;
            len_q      <= DEPTH;
        end else begin
            dac_strobe <= strobe_d;
            busy       <= busy_d;
            done       <= done_d;
            if (tick) begin
                dac_data <= rd_data;
            end
            if (accept) begin
                len_q   <= (len == '0) ? DEPTH : len;
                rd_addr <= '0;
                div_cnt <= '0;
            end else if (state_q == PLAY) begin
                div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    rd_addr <= last ? '0 : rd_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wave_player.sv
// Scoreboard bench for wave_player: stimulus pushes expected strobes and
// done pulses with their cycle numbers; a monitor pops and compares.
module tb_wave_player;

    localparam int DW  = 12;
    localparam int AW  = 10;
    localparam int DIV = 4;

    typedef struct {
        logic [DW-1:0] v;
        int            c;
    } smp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [AW:0]   len;
    logic [DW-1:0] dac_data;
    logic          dac_strobe;
    logic          busy;
    logic          done;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   t0;
    smp_t exp_q[$];
    int   done_q[$];
    smp_t ent;
    int   dc;

    wave_player #(.DW(DW), .AW(AW), .SMP_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .len        (len),
        .dac_data   (dac_data),
        .dac_strobe (dac_strobe),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (dac_strobe) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL strobe_extra cyc=%0d got=%0d required=none",
                             cyc, dac_data);
                end else begin
                    ent = exp_q.pop_front();
                    if (dac_data !== ent.v || cyc != ent.c) begin
                        fails++;
                        $display("FAIL strobe got=%0d@%0d required=%0d@%0d",
                                 dac_data, cyc, ent.v, ent.c);
                    end
                end
            end
            if (done) begin
                tests++;
                if (done_q.size() == 0) begin
                    fails++;
                    $display("FAIL done_extra cyc=%0d required=none", cyc);
                end else begin
                    dc = done_q.pop_front();
                    if (cyc != dc) begin
                        fails++;
                        $display("FAIL done_cycle got=%0d required=%0d", cyc, dc);
                    end
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got=%0d required=%0d", n, act, req);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = DW'(d);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic play(input int l, input logic lp);
        @(negedge clk);
        start   = 1'b1;
        len     = (AW+1)'(l);
        loop_en = lp;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic push(input int k, input int v);
        smp_t s;
        s.v = DW'(v);
        s.c = t0 + DIV * k;
        exp_q.push_back(s);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        len     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // idle after reset
        repeat (6) begin
            @(negedge clk);
            chk("idle_out", {dac_data, dac_strobe, busy, done}, 32'd0);
        end

        for (int i = 0; i < 4; i++) wr(i, 100 * (i + 1));

        // single shot
        play(4, 1'b0);
        for (int k = 1; k <= 4; k++) push(k, 100 * k);
        done_q.push_back(t0 + 17);
        chk("busy_start", busy, 1);
        wait_until(t0 + 15);
        chk("busy_last_m1", busy, 1);
        wait_until(t0 + 16);
        chk("busy_last", busy, 0);
        wait_until(t0 + 22);

        // looping, loop_en dropped before the 6th strobe
        play(3, 1'b1);
        for (int k = 1; k <= 6; k++) push(k, 100 * (((k - 1) % 3) + 1));
        done_q.push_back(t0 + 25);
        wait_until(t0 + 18);
        loop_en = 1'b0;
        wait_until(t0 + 30);
        chk("loop_end_busy", busy, 0);

        // stop coinciding with the 2nd tick
        play(4, 1'b0);
        push(1, 100);
        wait_until(t0 + 7);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_data", dac_data, 100);
        chk("stop_strobe", dac_strobe, 0);
        wait_until(t0 + 24);

        // start and stop together in idle
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", busy, 0);
        repeat (10) @(negedge clk);
        chk("startstop_idle", busy, 0);

        // rewrite mem[3] well ahead of its tick
        play(4, 1'b0);
        wr_en   = 1'b1;
        wr_addr = AW'(3);
        wr_data = DW'(777);
        @(negedge clk);
        wr_en = 1'b0;
        for (int k = 1; k <= 3; k++) push(k, 100 * k);
        push(4, 777);
        done_q.push_back(t0 + 17);
        wait_until(t0 + 22);
        wr(3, 400);

        // reset mid-play, memory retained
        play(4, 1'b0);
        push(1, 100);
        wait_until(t0 + 6);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_data", dac_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", dac_strobe, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        play(4, 1'b0);
        for (int k = 1; k <= 4; k++) push(k, 100 * k);
        done_q.push_back(t0 + 17);
        wait_until(t0 + 22);

        // full depth via len=0
        for (int i = 0; i < 1024; i++) wr(i, i);
        play(0, 1'b0);
        for (int k = 1; k <= 1024; k++) push(k, k - 1);
        done_q.push_back(t0 + DIV * 1024 + 1);
        wait_until(t0 + DIV * 1024 + 8);
        chk("full_busy", busy, 0);

        chk("strobes_pending", exp_q.size(), 0);
        chk("dones_pending", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
